// File: rtl/s_mem_pkg.sv
// Shared types and constants for the RC4 s_memory arbiter.
// Contents:
//   S_ADDR_W, S_DATA_W : s_memory address/data widths
//   req_id_t           : requester indices used by the RC4 phase FSMs
//   rd_ent_t           : read-tracking pipeline entry {valid, owner}
package s_mem_pkg;

  localparam int unsigned S_ADDR_W = 8;
  localparam int unsigned S_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_INIT = 2'd0,
    REQ_KSA  = 2'd1,
    REQ_PRGA = 2'd2
  } req_id_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
  } rd_ent_t;

endpackage

// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the s_memory arbiter.
// Signals (requester i occupies bit i, or byte [8i+7:8i] for addr/wdata):
//   req    : access request, level, held for the whole transaction
//   we     : write enable, sampled only in granted cycles
//   addr   : flattened addresses
//   wdata  : flattened write data
//   gnt    : registered one-hot grant
//   rvalid : one-cycle read-data strobe per requester
//   rdata  : read data broadcast to all requesters, qualified by rvalid
// Modports: master (phase FSMs), slave (arbiter).
interface s_mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   we;
  logic [NUM_REQ*8-1:0] addr;
  logic [NUM_REQ*8-1:0] wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rvalid;
  logic [7:0]           rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/s_mem_arb_pick.sv
// Combinational winner selection for the s_memory arbiter.
// Build option S_MEM_ARB_RR_EN: defined -> round-robin search starting at
// ptr + 1 (mod NUM_REQ); undefined -> fixed priority, lowest index wins,
// ptr ignored.
// Ports:
//   req     : request vector
//   ptr     : index of the last grant holder
//   win     : one-hot winner (all zero when no request)
//   win_idx : index of the winner
module s_mem_arb_pick #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [1:0]         win_idx
);

  logic found;

`ifdef S_MEM_ARB_RR_EN
  int idx;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx[1:0];
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    // Descending scan so the lowest requesting index is the last to write.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    win = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      win[i] = found && (win_idx == 2'(i));
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Arbiter for the single-port 256x8 s_memory shared by the RC4 phase FSMs
// (init, KSA swap, PRGA). A grant stays locked while the owner holds req, so
// read-modify-write swaps are atomic. Reads return with an RD_LAT-cycle
// rvalid strobe to the requester that issued them.
// Build option S_MEM_ARB_RR_EN: round-robin arbitration (default: fixed
// priority, lowest index wins).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : requester bus (slave modport of s_mem_arbiter_if)
//   mem_addr, mem_data, mem_wren : to s_memory
//   mem_q        : from s_memory
//   owner        : index of grant holder, valid while busy
//   busy         : a grant is held
module s_mem_arbiter
  import s_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  s_mem_arbiter_if.slave      bus,
  output logic [S_ADDR_W-1:0] mem_addr,
  output logic [S_DATA_W-1:0] mem_data,
  output logic                mem_wren,
  input  logic [S_DATA_W-1:0] mem_q,
  output logic [1:0]          owner,
  output logic                busy
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] win;
  logic [1:0]         win_idx;

  logic                own_req, own_we;
  logic [S_ADDR_W-1:0] own_addr;
  logic [S_DATA_W-1:0] own_wdata;
  logic                rd_push;

  rd_ent_t pipe_q [RD_LAT];
  rd_ent_t pipe_out;

  s_mem_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

`ifdef S_MEM_ARB_RR_EN
  logic [1:0] ptr_q;
  logic       grant_now;

  assign grant_now = (state_q == StIdle) && (|bus.req);

  // Reset to NUM_REQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 2'(NUM_REQ - 1);
    end else if (grant_now) begin
      ptr_q <= win_idx;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'(NUM_REQ - 1);
`endif

  // Owner's signals, selected by the registered grant; all zero with no grant.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_q[i]) begin
        own_req   = bus.req[i];
        own_we    = bus.we[i];
        own_addr  = bus.addr[i*S_ADDR_W +: S_ADDR_W];
        own_wdata = bus.wdata[i*S_DATA_W +: S_DATA_W];
      end
    end
  end

  // A granted cycle is an access only while the owner still holds req; this
  // also forces wren low on the releasing cycle.
  assign mem_addr = own_addr;
  assign mem_data = own_wdata;
  assign mem_wren = own_req & own_we;
  assign rd_push  = own_req & ~own_we;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StHold;
          gnt_d   = win;
          owner_d = win_idx;
        end
      end
      StHold: begin
        if (!own_req) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  // Read tracking runs independently of the grant so in-flight reads finish
  // after release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= rd_push;
      pipe_q[0].owner <= owner_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipe_out = pipe_q[RD_LAT-1];

  always_comb begin
    bus.rvalid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.rvalid[i] = pipe_out.valid && (pipe_out.owner == 2'(i));
    end
    bus.rdata = pipe_out.valid ? mem_q : '0;
  end

  assign bus.gnt = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == StHold);

endmodule

// File: tb/tb_s_mem_arbiter.sv
module tb_s_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int RD_LAT  = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] mem_addr, mem_data, mem_q;
  logic       mem_wren;
  logic [1:0] owner;
  logic       busy;

  s_mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  s_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_q    (mem_q),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // s_memory model: synchronous write, registered read, RD_LAT stages.
  logic [7:0] mem [256];
  logic [7:0] q0, q1;
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    q0 <= mem[mem_addr];
    q1 <= q0;
  end
  assign mem_q = (RD_LAT == 1) ? q0 : q1;

  typedef struct {
    int         own;
    logic [7:0] data;
    int         due;
  } sb_t;

  sb_t        sb [$];
  logic [7:0] shadow [256];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  int         exp_order [4];
  logic [7:0] tmp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d);
    bus.req[i]         = r;
    bus.we[i]          = w;
    bus.addr[i*8 +: 8]  = a;
    bus.wdata[i*8 +: 8] = d;
  endtask

  // Called in the cycle a read access is presented.
  task automatic push_rd(input int own, input logic [7:0] d);
    sb_t e;
    e.own  = own;
    e.data = d;
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
  endtask

  // Every cycle: rvalid must match the scoreboard head exactly, else be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        chk("rvalid", 32'(bus.rvalid), 32'(1 << sb[0].own));
        chk("rdata", 32'(bus.rdata), 32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        chk("rvalid_quiet", 32'(bus.rvalid), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
`ifdef S_MEM_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset_n   = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) tick();

    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wren", 32'(mem_wren), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single write by requester 0.
    drive(0, 1, 1, 8'h05, 8'hA5);
    #1;
    chk("t1_pre_gnt", 32'(bus.gnt), 0);
    chk("t1_pre_wren", 32'(mem_wren), 0);
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'b001);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_owner", 32'(owner), 0);
    chk("t1_wren", 32'(mem_wren), 1);
    chk("t1_addr", 32'(mem_addr), 32'h05);
    chk("t1_data", 32'(mem_data), 32'hA5);
    shadow[8'h05] = 8'hA5;
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("t1_rel_wren", 32'(mem_wren), 0);
    chk("t1_rel_gnt", 32'(bus.gnt), 32'b001);
    tick();
    chk("t1_end_gnt", 32'(bus.gnt), 0);
    chk("t1_end_busy", 32'(busy), 0);

    // Requester 1 reads back the written byte.
    drive(1, 1, 0, 8'h05, 8'h00);
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'b010);
    chk("t2_addr", 32'(mem_addr), 32'h05);
    chk("t2_wren", 32'(mem_wren), 0);
    push_rd(1, shadow[8'h05]);
    tick();
    drive(1, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t2_end_gnt", 32'(bus.gnt), 0);

    // Fresh pointer, then all three requesting; each owner does two reads.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1, 0, 8'h05, 8'h00);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t3_gnt", 32'(bus.gnt), 32'(1 << exp_order[g]));
      chk("t3_owner", 32'(owner), 32'(exp_order[g]));
      push_rd(exp_order[g], shadow[8'h05]);
      tick();
      push_rd(exp_order[g], shadow[8'h05]);
      tick();
      bus.req[exp_order[g]] = 1'b0;
      #1;
      chk("t3_rel_wren", 32'(mem_wren), 0);
      chk("t3_rel_gnt", 32'(bus.gnt), 32'(1 << exp_order[g]));
      tick();
      chk("t3_dead_gnt", 32'(bus.gnt), 0);
      if (g < 3) bus.req[exp_order[g]] = 1'b1;
    end
    // Requester 0 now idle: requester 1 wins, then drops on its grant cycle.
    tick();
    chk("t3_last_gnt", 32'(bus.gnt), 32'b010);
    bus.req = '0;
    #1;
    chk("t3_noacc_wren", 32'(mem_wren), 0);
    tick();
    chk("t3_end_gnt", 32'(bus.gnt), 0);

    // Seed 0x10/0x20 via requester 2.
    drive(2, 1, 1, 8'h10, 8'h11);
    tick();
    chk("t4_seed_gnt", 32'(bus.gnt), 32'b100);
    shadow[8'h10] = 8'h11;
    tick();
    drive(2, 1, 1, 8'h20, 8'h22);
    shadow[8'h20] = 8'h22;
    tick();
    drive(2, 0, 0, 8'h00, 8'h00);
    tick();

    // Locked swap by requester 1 while requester 0 waits.
    drive(1, 1, 0, 8'h10, 8'h00);
    tick();
    chk("t4_gnt_a", 32'(bus.gnt), 32'b010);
    push_rd(1, shadow[8'h10]);
    drive(0, 1, 0, 8'h10, 8'h00);
    tick();
    drive(1, 1, 0, 8'h20, 8'h00);
    push_rd(1, shadow[8'h20]);
    #1;
    chk("t4_gnt_b", 32'(bus.gnt), 32'b010);
    tick();
    drive(1, 1, 1, 8'h10, shadow[8'h20]);
    #1;
    chk("t4_gnt_c", 32'(bus.gnt), 32'b010);
    chk("t4_wr_wren", 32'(mem_wren), 1);
    chk("t4_wr_addr", 32'(mem_addr), 32'h10);
    tick();
    drive(1, 1, 1, 8'h20, shadow[8'h10]);
    #1;
    chk("t4_gnt_d", 32'(bus.gnt), 32'b010);
    chk("t4_wr2_data", 32'(mem_data), 32'h11);
    tmp           = shadow[8'h10];
    shadow[8'h10] = shadow[8'h20];
    shadow[8'h20] = tmp;
    tick();
    drive(1, 0, 0, 8'h00, 8'h00);
    #1;
    chk("t4_gnt_rel", 32'(bus.gnt), 32'b010);
    tick();
    chk("t4_dead_gnt", 32'(bus.gnt), 0);
    tick();
    chk("t4_gnt0", 32'(bus.gnt), 32'b001);
    push_rd(0, 8'h22);
    tick();
    drive(0, 1, 0, 8'h20, 8'h00);
    push_rd(0, 8'h11);
    tick();
    drive(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t4_end_gnt", 32'(bus.gnt), 0);

    // Requester 2 reads then releases; its rvalid must still arrive.
    drive(2, 1, 0, 8'h05, 8'h00);
    tick();
    chk("t5_gnt2", 32'(bus.gnt), 32'b100);
    push_rd(2, shadow[8'h05]);
    drive(0, 1, 0, 8'h05, 8'h00);
    tick();
    drive(2, 0, 0, 8'h00, 8'h00);
    #1;
    chk("t5_rel_gnt", 32'(bus.gnt), 32'b100);
    tick();
    chk("t5_dead_gnt", 32'(bus.gnt), 0);
    tick();
    chk("t5_gnt0", 32'(bus.gnt), 32'b001);
    drive(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t5_end_gnt", 32'(bus.gnt), 0);

    // Reset during a granted read: the read must never report.
    drive(1, 1, 0, 8'h05, 8'h00);
    tick();
    chk("t6_gnt", 32'(bus.gnt), 32'b010);
    reset_n = 1'b0;
    tick();
    bus.req = '0;
    #1;
    chk("t6_gnt_rst", 32'(bus.gnt), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_rvalid_rst", 32'(bus.rvalid), 0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
